// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one memory port between the instruction-fetch side (i_*) and the
// data load/store side (d_*). One access is in flight at a time. Ties alternate between sides,
// and an access whose mem_ready never arrives is aborted after TIMEOUT+1 cycles with bus_error.
//
// Ports
//   clk, rst             clock (rising edge), asynchronous active-low reset
//   i_req, i_addr        fetch request (level, held until i_ack) and address
//   i_rdata, i_ack       fetched word and one-cycle completion pulse
//   d_re, d_we           data read / write request (level, held until d_ack; both = write)
//   d_addr, d_wdata      data address and write data
//   d_be                 data byte enables
//   d_rdata, d_ack       read data and one-cycle completion pulse
//   mem_req, mem_we      memory access in progress, write strobe
//   mem_addr, mem_wdata  memory address and write data
//   mem_be               memory byte enables
//   mem_rdata, mem_ready memory read data and completion of the current access
//   stall                a request is pending and not yet acknowledged
//   bus_error            pulses with the ack of a timed-out access
module mem_bus_arbiter #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic [DATA_W-1:0]   i_rdata,
  output logic                i_ack,
  input  logic                d_re,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_be,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_ack,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_ready,
  output logic                stall,
  output logic                bus_error
);

  localparam int unsigned BeW  = DATA_W / 8;
  localparam int unsigned CntW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

  state_e state_q, state_d;

  // owner_q / last_grant_q: 1 = data side, 0 = fetch side
  logic              owner_q;
  logic              last_grant_q;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [DATA_W-1:0] wdata_q;
  logic [BeW-1:0]    be_q;
  logic [CntW-1:0]   cnt_q;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;

  logic d_req;
  logic any_req;
  logic grant_d;
  logic timeout_hit;

  assign d_req   = d_re | d_we;
  assign any_req = i_req | d_req;
  // Under contention the side that was not served last wins.
  assign grant_d = d_req & (~i_req | ~last_grant_q);
  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CntW'(TIMEOUT));

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; mem_ready takes priority over an expiring timeout.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (any_req) state_d = StAccess;
      StAccess: if (mem_ready || timeout_hit) state_d = StResp;
      StResp:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Access registers: latched at grant so the memory port ignores requester changes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner_q      <= 1'b0;
      last_grant_q <= 1'b0;
      addr_q       <= '0;
      we_q         <= 1'b0;
      wdata_q      <= '0;
      be_q         <= '0;
      cnt_q        <= '0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (any_req) begin
            owner_q <= grant_d;
            addr_q  <= grant_d ? d_addr : i_addr;
            we_q    <= grant_d & d_we;
            wdata_q <= grant_d ? d_wdata : '0;
            be_q    <= grant_d ? d_be : '1;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
          end
        end
        StAccess: begin
          if (mem_ready) begin
            rdata_q <= we_q ? '0 : mem_rdata;
          end else if (timeout_hit) begin
            err_q   <= 1'b1;
            rdata_q <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StResp: last_grant_q <= owner_q;
        default: ;
      endcase
    end
  end

  // Outputs
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_be    = '0;
    i_ack     = 1'b0;
    d_ack     = 1'b0;
    bus_error = 1'b0;
    unique case (state_q)
      StAccess: begin
        mem_req   = 1'b1;
        mem_we    = we_q;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        mem_be    = be_q;
      end
      StResp: begin
        i_ack     = ~owner_q;
        d_ack     = owner_q;
        bus_error = err_q;
      end
      default: ;
    endcase
    i_rdata = i_ack ? rdata_q : '0;
    d_rdata = d_ack ? rdata_q : '0;
    // Gated by rst so the control unit never sees a stall while reset is held.
    stall   = rst & ((i_req & ~i_ack) | (d_req & ~d_ack));
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Testbench for mem_bus_arbiter: table-driven directed vectors, hand-written reset-mid-access
// sequence, and randomized traffic checked against a transaction-timing reference model.
module tb_mem_bus_arbiter;

  localparam int unsigned TO = 4;

  logic        clk;
  logic        rst;
  logic        i_req;
  logic [31:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_ack;
  logic        d_re;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_be;
  logic [31:0] d_rdata;
  logic        d_ack;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        stall;
  logic        bus_error;

  int checks = 0;
  int errors = 0;

  mem_bus_arbiter #(
    .ADDR_W (32),
    .DATA_W (32),
    .TIMEOUT(TO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .i_req    (i_req),
    .i_addr   (i_addr),
    .i_rdata  (i_rdata),
    .i_ack    (i_ack),
    .d_re     (d_re),
    .d_we     (d_we),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_be     (d_be),
    .d_rdata  (d_rdata),
    .d_ack    (d_ack),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_be   (mem_be),
    .mem_rdata(mem_rdata),
    .mem_ready(mem_ready),
    .stall    (stall),
    .bus_error(bus_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Output vector: {mem_req, mem_we, mem_addr, mem_wdata, mem_be, i_ack, i_rdata,
  //                 d_ack, d_rdata, stall, bus_error}
  function automatic logic [137:0] pk(input logic mr, mw, input logic [31:0] ma, mwd,
                                      input logic [3:0] mb, input logic ia,
                                      input logic [31:0] ird, input logic da,
                                      input logic [31:0] drd, input logic st, be);
    return {mr, mw, ma, mwd, mb, ia, ird, da, drd, st, be};
  endfunction

  // Fields that carry no meaning in a cycle are ignored, except under reset where all are 0.
  function automatic logic [137:0] cr(input logic r, mr, mw, ia, da);
    logic cm, cw;
    cm = ~r | mr;
    cw = ~r | mw;
    return pk(1'b1, cm, {32{cm}}, {32{cw}}, {4{cm}}, 1'b1, {32{~r | ia}}, 1'b1,
              {32{~r | da}}, 1'b1, 1'b1);
  endfunction

  task automatic check_vec(input string name, input logic [137:0] exp, input logic [137:0] care);
    logic [137:0] act;
    act = pk(mem_req, mem_we, mem_addr, mem_wdata, mem_be, i_ack, i_rdata, d_ack, d_rdata,
             stall, bus_error);
    checks++;
    if ((act & care) !== (exp & care)) begin
      errors++;
      $display("FAIL %s: outputs %h, required %h", name, act & care, exp & care);
    end
  endtask

  task automatic check_bits(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, ir, input logic [31:0] ia, input logic re, we,
                       input logic [31:0] da, dw, input logic [3:0] db, input logic rdy,
                       input logic [31:0] rd);
    rst       = r;
    i_req     = ir;
    i_addr    = ia;
    d_re      = re;
    d_we      = we;
    d_addr    = da;
    d_wdata   = dw;
    d_be      = db;
    mem_ready = rdy;
    mem_rdata = rd;
  endtask

  typedef struct {
    logic [4:0]   f;      // {rst, i_req, d_re, d_we, mem_ready}
    logic [31:0]  ia, da, dw, rd;
    logic [3:0]   db;
    logic [137:0] exp, care;
  } vec_t;

  vec_t cur;
  vec_t vecs[$];

  task automatic vi(input logic [4:0] f, input logic [31:0] ia, da, dw,
                    input logic [3:0] db, input logic [31:0] rd);
    cur.f = f; cur.ia = ia; cur.da = da; cur.dw = dw; cur.db = db; cur.rd = rd;
  endtask

  // f = {mem_req, mem_we, i_ack, d_ack, stall, bus_error}
  task automatic ve(input logic [5:0] f, input logic [31:0] ma, mwd, input logic [3:0] mb,
                    input logic [31:0] ird, drd);
    cur.exp  = pk(f[5], f[4], ma, mwd, mb, f[3], ird, f[2], drd, f[1], f[0]);
    cur.care = cr(cur.f[4], f[5], f[4], f[3], f[2]);
    vecs.push_back(cur);
  endtask

  task automatic fill_table();
    logic        dd, lst;
    logic [31:0] rv;
    // Reset holds every output at 0 even with requests asserted
    vi(5'b01111, 'h100, 'h55, 'h66, 4'hf, 'h77);     ve(6'b000000, 0, 0, 4'h0, 0, 0);
    // Single fetch, ready in the first access cycle
    vi(5'b11000, 'h100, 0, 0, 4'h0, 0);              ve(6'b000010, 0, 0, 4'h0, 0, 0);
    vi(5'b11001, 'h100, 0, 0, 4'h0, 'h00500093);     ve(6'b100010, 'h100, 0, 4'hf, 0, 0);
    vi(5'b10000, 0, 0, 0, 4'h0, 0);                  ve(6'b001000, 0, 0, 4'h0, 'h00500093, 0);
    vi(5'b10000, 0, 0, 0, 4'h0, 0);                  ve(6'b000000, 0, 0, 4'h0, 0, 0);
    // Write with three wait states; requester fields wiggle mid-access
    vi(5'b10010, 0, 'h2004, 'hDEADBEEF, 4'h3, 0);    ve(6'b000010, 0, 0, 4'h0, 0, 0);
    vi(5'b10010, 0, 'h2004, 'hDEADBEEF, 4'h3, 0);    ve(6'b110010, 'h2004, 'hDEADBEEF, 4'h3, 0, 0);
    vi(5'b10010, 0, 'h9999, 'h11111111, 4'hc, 0);    ve(6'b110010, 'h2004, 'hDEADBEEF, 4'h3, 0, 0);
    vi(5'b10010, 0, 'h2004, 'hDEADBEEF, 4'h3, 0);    ve(6'b110010, 'h2004, 'hDEADBEEF, 4'h3, 0, 0);
    vi(5'b10011, 0, 'h2004, 'hDEADBEEF, 4'h3, 'hAAAA5555);
    ve(6'b110010, 'h2004, 'hDEADBEEF, 4'h3, 0, 0);
    vi(5'b10000, 0, 0, 0, 4'h0, 0);                  ve(6'b000100, 0, 0, 4'h0, 0, 0);
    // mem_ready while idle is ignored
    vi(5'b10001, 0, 0, 0, 4'h0, 'h1);                ve(6'b000000, 0, 0, 4'h0, 0, 0);
    vi(5'b00000, 0, 0, 0, 4'h0, 0);                  ve(6'b000000, 0, 0, 4'h0, 0, 0);
    // Contention straight after reset: D first, then I
    vi(5'b11100, 'h400, 'h800, 0, 4'hf, 0);          ve(6'b000010, 0, 0, 4'h0, 0, 0);
    vi(5'b11101, 'h400, 'h800, 0, 4'hf, 'hD0D0D0D0); ve(6'b100010, 'h800, 0, 4'hf, 0, 0);
    vi(5'b11000, 'h400, 0, 0, 4'h0, 0);              ve(6'b000110, 0, 0, 4'h0, 0, 'hD0D0D0D0);
    vi(5'b11000, 'h400, 0, 0, 4'h0, 0);              ve(6'b000010, 0, 0, 4'h0, 0, 0);
    vi(5'b11001, 'h400, 0, 0, 4'h0, 'h11223344);     ve(6'b100010, 'h400, 0, 4'hf, 0, 0);
    vi(5'b10000, 0, 0, 0, 4'h0, 0);                  ve(6'b001000, 0, 0, 4'h0, 'h11223344, 0);
    // Alternation with both sides held: D, I, D, I
    for (int k = 0; k < 4; k++) begin
      dd  = (k % 2 == 0);
      lst = (k == 3);
      rv  = 32'hA0 + k;
      vi(5'b11100, 'h400, 'h800, 0, 4'hf, 0);        ve(6'b000010, 0, 0, 4'h0, 0, 0);
      vi(5'b11101, 'h400, 'h800, 0, 4'hf, rv);
      ve(6'b100010, dd ? 'h800 : 'h400, 0, 4'hf, 0, 0);
      if (lst) vi(5'b10000, 0, 0, 0, 4'h0, 0);
      else     vi(5'b11100, 'h400, 'h800, 0, 4'hf, 0);
      ve({2'b00, ~dd, dd, ~lst, 1'b0}, 0, 0, 4'h0, dd ? 0 : rv, dd ? rv : 0);
    end
    vi(5'b10000, 0, 0, 0, 4'h0, 0);                  ve(6'b000000, 0, 0, 4'h0, 0, 0);
    // Timeout: mem_req for TO+1 cycles, then d_ack with bus_error and zero data
    vi(5'b10100, 0, 'h30, 0, 4'hf, 0);               ve(6'b000010, 0, 0, 4'h0, 0, 0);
    for (int k = 0; k <= TO; k++) begin
      vi(5'b10100, 0, 'h30, 0, 4'hf, 'h1234);        ve(6'b100010, 'h30, 0, 4'hf, 0, 0);
    end
    vi(5'b10000, 0, 0, 0, 4'h0, 'h1234);             ve(6'b000101, 0, 0, 4'h0, 0, 0);
    vi(5'b10000, 0, 0, 0, 4'h0, 0);                  ve(6'b000000, 0, 0, 4'h0, 0, 0);
    // mem_ready on the last allowed cycle beats the timeout
    vi(5'b11000, 'h500, 0, 0, 4'h0, 0);              ve(6'b000010, 0, 0, 4'h0, 0, 0);
    for (int k = 0; k < TO; k++) begin
      vi(5'b11000, 'h500, 0, 0, 4'h0, 0);            ve(6'b100010, 'h500, 0, 4'hf, 0, 0);
    end
    vi(5'b11001, 'h500, 0, 0, 4'h0, 'hCAFEF00D);     ve(6'b100010, 'h500, 0, 4'hf, 0, 0);
    vi(5'b10000, 0, 0, 0, 4'h0, 0);                  ve(6'b001000, 0, 0, 4'h0, 'hCAFEF00D, 0);
    vi(5'b10000, 0, 0, 0, 4'h0, 0);                  ve(6'b000000, 0, 0, 4'h0, 0, 0);
  endtask

  task automatic reset_mid_access();
    logic seen;
    tick(); drive(1, 1, 'h600, 0, 0, 0, 0, 4'h0, 0, 0);
    tick(); drive(1, 1, 'h600, 0, 0, 0, 0, 4'h0, 0, 0);
    #2 check_bits("mid_rst_access", {31'd0, mem_req}, 1);
    #1 rst = 1'b0;
    #1 check_bits("mid_rst_drop", {28'd0, mem_req, stall, i_ack, d_ack}, 0);
    tick(); drive(1, 1, 'h600, 0, 0, 0, 0, 4'h0, 1, 'h0BADF00D);
    seen = 1'b0;
    for (int n = 0; n < 10 && !seen; n++) begin
      tick();
      #2 if (i_ack) seen = 1'b1;
    end
    check_bits("mid_rst_ack_seen", {31'd0, seen}, 1);
    check_bits("mid_rst_rdata", i_rdata, 'h0BADF00D);
    check_bits("mid_rst_err", {31'd0, bus_error}, 0);
    tick(); drive(1, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0);
  endtask

  // Randomized traffic. The model tracks one transaction by cycle numbers: granted in cycle
  // g, memory answers after lat wait cycles, ack at g+2+min(lat,TO), next grant possible after.
  task automatic random_traffic(input int ncyc);
    logic        r_ir, r_dre, r_dwe, r_rdy;
    logic [31:0] r_ia, r_da, r_dw, r_rd;
    logic [3:0]  r_db;
    logic        busy, own_d, last_d, t_we, t_err;
    logic [31:0] t_addr, t_wdata, t_rdata;
    logic [3:0]  t_be;
    logic        in_acc, ack_now, e_ia, e_da, renew;
    int          g, a, lat, idle_from, kind;
    r_ir = 0; r_dre = 0; r_dwe = 0; r_ia = 0; r_da = 0; r_dw = 0; r_db = 0;
    busy = 0; own_d = 0; last_d = 0; t_we = 0; t_err = 0;
    t_addr = 0; t_wdata = 0; t_rdata = 0; t_be = 0;
    g = 0; a = 0; lat = 0; idle_from = 0;
    tick(); drive(0, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0);
    tick(); drive(1, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0);
    for (int cyc = 0; cyc < ncyc; cyc++) begin
      tick();
      in_acc  = busy && cyc > g && cyc < a;
      ack_now = busy && cyc == a;
      e_ia    = ack_now && !own_d;
      e_da    = ack_now && own_d;
      // Requesters hold until acked; on the ack cycle they drop or renew.
      if (r_ir) begin
        if (e_ia) begin
          r_ir = ($urandom_range(0, 1) == 1);
          r_ia = $urandom;
        end
      end else begin
        r_ir = ($urandom_range(0, 2) == 0);
        r_ia = $urandom;
      end
      if (r_dre || r_dwe) renew = e_da ? ($urandom_range(0, 1) == 1) : 1'b1;
      else                renew = ($urandom_range(0, 2) == 0);
      if (!(r_dre || r_dwe) || e_da) begin
        kind  = $urandom_range(0, 2);
        r_dre = renew && (kind != 1);
        r_dwe = renew && (kind != 0);
        r_da  = $urandom;
        r_dw  = $urandom;
        r_db  = 4'($urandom_range(0, 15));
      end
      r_rd = $urandom;
      if (in_acc) begin
        r_rdy = !t_err && (cyc == g + 1 + lat);
        if (r_rdy) t_rdata = t_we ? 32'd0 : r_rd;
      end else begin
        r_rdy = ($urandom_range(0, 1) == 1);
      end
      drive(1, r_ir, r_ia, r_dre, r_dwe, r_da, r_dw, r_db, r_rdy, r_rd);
      #2;
      check_vec($sformatf("rand@%0d", cyc),
                pk(in_acc, in_acc & t_we, in_acc ? t_addr : 0, in_acc ? t_wdata : 0,
                   in_acc ? t_be : 4'h0, e_ia, e_ia ? t_rdata : 0, e_da, e_da ? t_rdata : 0,
                   (r_ir & ~e_ia) | ((r_dre | r_dwe) & ~e_da), ack_now & t_err),
                cr(1'b1, in_acc, in_acc & t_we, e_ia, e_da));
      if (ack_now) begin
        busy      = 0;
        last_d    = own_d;
        idle_from = cyc + 1;
      end
      if (!busy && cyc >= idle_from && (r_ir || r_dre || r_dwe)) begin
        own_d   = (r_ir && (r_dre || r_dwe)) ? !last_d : (r_dre || r_dwe);
        t_addr  = own_d ? r_da : r_ia;
        t_we    = own_d && r_dwe;
        t_wdata = own_d ? r_dw : 32'd0;
        t_be    = own_d ? r_db : 4'hf;
        t_rdata = 0;
        g       = cyc;
        lat     = $urandom_range(0, 7);
        t_err   = (lat > TO);
        a       = g + 2 + ((lat > TO) ? TO : lat);
        busy    = 1;
      end
    end
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0);
    repeat (2) @(posedge clk);
    fill_table();
    foreach (vecs[i]) begin
      tick();
      drive(vecs[i].f[4], vecs[i].f[3], vecs[i].ia, vecs[i].f[2], vecs[i].f[1], vecs[i].da,
            vecs[i].dw, vecs[i].db, vecs[i].f[0], vecs[i].rd);
      #2 check_vec($sformatf("vec[%0d]", i), vecs[i].exp, vecs[i].care);
    end
    reset_mid_access();
    random_traffic(2000);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
